seq_restoring_divider_16_8: RTL and testbench
=============================================

// Module: seq_restoring_divider_16_8
// PURPOSE
//  Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient, 8-bit remainder.
//  Inverse operation of the 8x8 approximate multipliers; used in error-characterisation and round-trip checks (P/B -> A).
//  Optional early termination (SKIP) drops the final iterations, giving an approximate-quotient variant in the same family.
// PARAMETERS
//  DW    16  dividend / quotient width
//  VW    8   divisor / remainder width
//  SKIP  0   iterations omitted at the end (0..DW-1); quotient LSBs [SKIP-1:0] forced 0
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   operands valid
//  in_ready     out  1   divider idle, can accept
//  dividend     in   DW  unsigned dividend
//  divisor      in   VW  unsigned divisor
//  out_valid    out  1   result valid
//  out_ready    in   1   consumer accepts result
//  quotient     out  DW  unsigned quotient
//  remainder    out  VW  unsigned (partial) remainder
//  div_by_zero  out  1   divisor was 0 for this result
// BEHAVIOUR
//  Reset: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
//  Reset mid-operation aborts the operation; no result is produced for it.
//  FSM IDLE -> CALC -> DONE -> IDLE. in_ready = (state==IDLE). out_valid = (state==DONE).
//  IDLE: on in_valid&&in_ready edge, latch operands, clear partial remainder (VW+1 bits), cnt=0.
//        divisor!=0 -> CALC; divisor==0 -> DONE directly: quotient={DW{1'b1}}, remainder=dividend[VW-1:0], div_by_zero=1.
//  CALC: one iteration per cycle, MSB first: r' = {r[VW-1:0], dividend[DW-1-cnt]}; if r' >= divisor, r = r' - divisor
//        and qbit=1, else r = r' and qbit=0. Quotient bit DW-1-cnt = qbit. cnt++.
//        After DW-SKIP iterations (cnt==DW-SKIP-1 processed) -> DONE; quotient[SKIP-1:0]=0; remainder = r[VW-1:0].
//  Latency: acceptance edge E0, out_valid visible after edge E(DW-SKIP); DW=16, SKIP=0 -> 16 cycles.
//  DONE: quotient/remainder/div_by_zero held stable while out_valid && !out_ready; out_ready -> IDLE next edge.
//        No same-cycle accept in DONE; back-to-back throughput is one result per DW-SKIP+2 cycles.
//  in_valid while busy is ignored (not latched); operand inputs are don't-care outside the accept cycle.
//  div_by_zero cleared on next accept. SKIP=0 results are exact: dividend = quotient*divisor + remainder, remainder < divisor.
//  Partial remainder is VW+1 bits wide; no overflow possible for any input. Comparison/subtraction are unsigned.
// STRUCTURE
//  Package div_pkg: state enum (IDLE, CALC, DONE), DW/VW defaults, counter width $clog2(DW).
//  Sub-module div_step (combinational): inputs r, next dividend bit, divisor; outputs r_next, qbit.
//  Top: FSM, counter, operand/quotient/remainder registers, handshake.
// TESTING
//  1. 50000/7, SKIP=0 -> quotient 7142, remainder 6, div_by_zero 0, out_valid 16 cycles after accept.
//  2. 65535/255 -> quotient 257, remainder 0; 5/9 -> quotient 0, remainder 5.
//  3. 100/0 -> quotient 0xFFFF, remainder 100, div_by_zero 1, out_valid the cycle after accept.
//  4. Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, in_valid pulses ignored.
//  5. rst_n low at iteration 8 -> out_valid=0, in_ready=1 immediately; next op 1000/3 -> 333 r 1.
//  6. SKIP=4: 50000/7 -> quotient 7136, remainder 3, latency 12; random sweep vs model for SKIP in {0,4}.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider family.
package div_pkg;

  localparam int DIV_DW = 16;
  localparam int DIV_VW = 8;
  localparam int DIV_CW = $clog2(DIV_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; the partial remainder is VW+1 bits so the shifted value never overflows.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   r_next_o,
  output logic          qbit_o
);

  logic [VW+1:0] r_sh;
  logic [VW+1:0] dvs_ext;

  assign r_sh     = {r_i, bit_i};
  assign dvs_ext  = {2'b00, divisor_i};
  assign qbit_o   = (r_sh >= dvs_ext);
  assign r_next_o = qbit_o ? (VW+1)'(r_sh - dvs_ext) : r_sh[VW:0];

endmodule

// File: rtl/seq_restoring_divider_16_8.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Accept -> result after DW-SKIP cycles (next cycle on divide-by-zero); result held until out_ready.
module seq_restoring_divider_16_8
  import div_pkg::*;
#(
  parameter int DW   = DIV_DW,
  parameter int VW   = DIV_VW,
  parameter int SKIP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - SKIP - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   r_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          dbz_q;

  logic [VW:0]   r_d;
  logic          qbit_d;
  logic [DW-1:0] quot_d;

  div_step #(.VW(VW)) u_step (
    .r_i       (r_q),
    .bit_i     (dvd_q[DW-1]),
    .divisor_i (dvs_q),
    .r_next_o  (r_d),
    .qbit_o    (qbit_d)
  );

  // Quotient bits enter at the LSB; the final shift realigns them when SKIP iterations are dropped.
  assign quot_d = {quot_q[DW-2:0], qbit_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            r_q   <= '0;
            cnt_q <= '0;
            if (divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= dividend[VW-1:0];
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              quot_q  <= '0;
              dbz_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          dvd_q <= {dvd_q[DW-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            quot_q  <= quot_d << SKIP;
            rem_q   <= r_d[VW-1:0];
            state_q <= DONE;
          end else begin
            quot_q  <= quot_d;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider_16_8.sv
// Bench for the restoring divider: exact (SKIP=0) and truncated (SKIP=4) instances against an arithmetic model.
module tb_seq_restoring_divider_16_8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv0, iv4, or0, or4;
  logic [15:0] a0, a4;
  logic [7:0]  b0, b4;
  wire         ir0, ir4, ov0, ov4, z0, z4;
  wire  [15:0] q0, q4;
  wire  [7:0]  r0, r4;

  int n_chk  = 0;
  int n_fail = 0;

  seq_restoring_divider_16_8 #(.SKIP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .dividend(a0), .divisor(b0),
    .out_valid(ov0), .out_ready(or0), .quotient(q0), .remainder(r0), .div_by_zero(z0)
  );

  seq_restoring_divider_16_8 #(.SKIP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .dividend(a4), .divisor(b4),
    .out_valid(ov4), .out_ready(or4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [15:0] a, input logic [7:0] b);
    if (s == 0) begin iv0 = v; a0 = a; b0 = b; end
    else        begin iv4 = v; a4 = a; b4 = b; end
  endtask

  task automatic set_ordy(input int s, input logic v);
    if (s == 0) or0 = v; else or4 = v;
  endtask

  // f: 0 in_ready, 1 out_valid, 2 quotient, 3 remainder, 4 div_by_zero
  function automatic logic [31:0] obs(input int s, input int f);
    logic [31:0] v;
    v = '0;
    case (f)
      0: v = {31'd0, (s == 0) ? ir0 : ir4};
      1: v = {31'd0, (s == 0) ? ov0 : ov4};
      2: v = {16'd0, (s == 0) ? q0  : q4};
      3: v = {24'd0, (s == 0) ? r0  : r4};
      default: v = {31'd0, (s == 0) ? z0 : z4};
    endcase
    return v;
  endfunction

  // Dropping SKIP final iterations is the same as dividing the dividend with its SKIP LSBs discarded.
  function automatic void model(input int s, input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic z, output int lat);
    int sk, t, d;
    sk = (s == 0) ? 0 : 4;
    if (b == 8'd0) begin
      q = 16'hFFFF; r = a[7:0]; z = 1'b1; lat = 0;
    end else begin
      t = int'(a) >> sk;
      d = int'(b);
      q = 16'((t / d) << sk);
      r = 8'(t % d);
      z = 1'b0;
      lat = 16 - sk;
    end
  endfunction

  task automatic run_op(input int s, input logic [15:0] a, input logic [7:0] b,
                        input int hold, input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          elat, lat;
    model(s, a, b, eq, er, ez, elat);
    @(negedge clk);
    drive(s, 1'b1, a, b);
    chk({tag, ".in_ready"}, obs(s, 0), 32'd1);
    @(posedge clk); #1;
    drive(s, 1'b0, 16'($urandom), 8'($urandom));
    lat = 0;
    while (obs(s, 1) !== 32'd1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".quotient"}, obs(s, 2), {16'd0, eq});
    chk({tag, ".remainder"}, obs(s, 3), {24'd0, er});
    chk({tag, ".dbz"}, obs(s, 4), {31'd0, ez});
    chk({tag, ".busy"}, obs(s, 0), 32'd0);
    repeat (hold) begin
      @(negedge clk);
      drive(s, 1'b1, 16'($urandom), 8'($urandom));
      @(posedge clk); #1;
      drive(s, 1'b0, 16'($urandom), 8'($urandom));
      chk({tag, ".hold_valid"}, obs(s, 1), 32'd1);
      chk({tag, ".hold_ready"}, obs(s, 0), 32'd0);
      chk({tag, ".hold_q"}, obs(s, 2), {16'd0, eq});
      chk({tag, ".hold_r"}, obs(s, 3), {24'd0, er});
      chk({tag, ".hold_dbz"}, obs(s, 4), {31'd0, ez});
    end
    @(negedge clk);
    set_ordy(s, 1'b1);
    @(posedge clk); #1;
    set_ordy(s, 1'b0);
    chk({tag, ".drain_valid"}, obs(s, 1), 32'd0);
    chk({tag, ".drain_ready"}, obs(s, 0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 16'd0, 8'd0);
    drive(4, 1'b0, 16'd0, 8'd0);
    or0 = 1'b0;
    or4 = 1'b0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("reset.in_ready", obs(s, 0), 32'd1);
      chk("reset.out_valid", obs(s, 1), 32'd0);
      chk("reset.quotient", obs(s, 2), 32'd0);
      chk("reset.remainder", obs(s, 3), 32'd0);
      chk("reset.dbz", obs(s, 4), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 16'd50000, 8'd7,   0,  "d50000_7");
    run_op(0, 16'd65535, 8'd255, 0,  "d65535_255");
    run_op(0, 16'd5,     8'd9,   0,  "d5_9");
    run_op(0, 16'd100,   8'd0,   0,  "d100_0");
    run_op(0, 16'd40000, 8'd13,  10, "backpressure");
    run_op(0, 16'd777,   8'd1,   0,  "div_by_1");
    run_op(4, 16'd50000, 8'd7,   0,  "skip4_50000_7");
    run_op(4, 16'd100,   8'd0,   2,  "skip4_div0");

    // Abort mid-calculation, then confirm the divider is immediately usable again.
    @(negedge clk);
    drive(0, 1'b1, 16'd50000, 8'd7);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'd0, 8'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", {31'd0, ov0}, 32'd0);
    chk("abort.in_ready", {31'd0, ir0}, 32'd1);
    chk("abort.quotient", {16'd0, q0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'd1000, 8'd3, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      for (int s = 0; s < 2; s++) begin
        logic [7:0] b;
        b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        run_op(s, 16'($urandom), b, $urandom_range(0, 2), (s == 0) ? "rand_skip0" : "rand_skip4");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
